// File: rtl/text_cursor_controller_if.sv
// Key-event handshake and grid write-command bundle for text_cursor_controller.
interface text_cursor_controller_if #(
   parameter int SCREEN_WIDTH  = 76,
   parameter int SCREEN_HEIGHT = 42
);
   localparam int ADDR_W = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);
   localparam int COL_W  = $clog2(SCREEN_WIDTH);
   localparam int ROW_W  = $clog2(SCREEN_HEIGHT);

   logic              key_valid;
   logic [7:0]        key_data;
   logic              key_ready;
   logic              clear_req;
   logic              te_write_en;
   logic [ADDR_W-1:0] te_addr;
   logic [7:0]        te_input;
   logic [COL_W-1:0]  cursor_col;
   logic [ROW_W-1:0]  cursor_row;
   logic              busy;

   modport master (
      output key_valid, key_data, clear_req,
      input  key_ready, te_write_en, te_addr, te_input, cursor_col, cursor_row, busy
   );

   modport slave (
      input  key_valid, key_data, clear_req,
      output key_ready, te_write_en, te_addr, te_input, cursor_col, cursor_row, busy
   );
endinterface

// File: rtl/text_cursor_controller.sv
// Write-side stage for the character grid: turns key events into cursor
// movement and single-cycle grid writes, and runs a full-screen clear.
module text_cursor_controller #(
   parameter int         SCREEN_WIDTH  = 76,
   parameter int         SCREEN_HEIGHT = 42,
   parameter logic [7:0] BLANK_CHAR    = 8'h20
) (
   input logic                      pixel_clk_in,
   input logic                      rst_in,
   text_cursor_controller_if.slave  bus
);
   localparam int CELLS  = SCREEN_WIDTH * SCREEN_HEIGHT;
   localparam int ADDR_W = $clog2(CELLS);
   localparam int COL_W  = $clog2(SCREEN_WIDTH);
   localparam int ROW_W  = $clog2(SCREEN_HEIGHT);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
   localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(SCREEN_WIDTH - 1);
   localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(SCREEN_HEIGHT - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state_q, state_n;
   logic              we_q, we_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [7:0]        data_q, data_n;
   logic [COL_W-1:0]  col_q, col_n;
   logic [ROW_W-1:0]  row_q, row_n;
   logic              busy_q, busy_n;
   logic              accept;

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] c);
      return ADDR_W'(r) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(c);
   endfunction

   assign bus.key_ready = (state_q == IDLE) && !bus.clear_req;
   assign accept        = bus.key_valid && bus.key_ready;

   assign bus.te_write_en = we_q;
   assign bus.te_addr     = addr_q;
   assign bus.te_input    = data_q;
   assign bus.cursor_col  = col_q;
   assign bus.cursor_row  = row_q;
   assign bus.busy        = busy_q;

   // State register.
   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) state_q <= IDLE;
      else        state_q <= state_n;
   end

   // Next state: enter CLEAR on request, leave once the last cell has been written.
   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE:    if (bus.clear_req) state_n = CLEAR;
         CLEAR:   if (addr_q == LAST_ADDR) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Next output values: key handling in IDLE, address sweep in CLEAR.
   // The clear sweep reuses the write-address register as its counter; the
   // first blank is issued on the entry edge so the strobe spans exactly CELLS cycles.
   always_comb begin
      we_n   = 1'b0;
      addr_n = addr_q;
      data_n = data_q;
      col_n  = col_q;
      row_n  = row_q;
      busy_n = busy_q;
      case (state_q)
         IDLE: begin
            if (bus.clear_req) begin
               we_n   = 1'b1;
               addr_n = '0;
               data_n = BLANK_CHAR;
               busy_n = 1'b1;
            end else if (accept) begin
               if (bus.key_data >= 8'h20 && bus.key_data <= 8'h7E) begin
                  we_n   = 1'b1;
                  addr_n = cell_addr(row_q, col_q);
                  data_n = bus.key_data;
                  if (col_q == COL_MAX) begin
                     col_n = '0;
                     row_n = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
                  end else begin
                     col_n = col_q + 1'b1;
                  end
               end else if (bus.key_data == 8'h0A) begin
                  col_n = '0;
                  row_n = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
               end else if (bus.key_data == 8'h08) begin
                  if (col_q != '0) begin
                     col_n = col_q - 1'b1;
                  end else if (row_q != '0) begin
                     col_n = COL_MAX;
                     row_n = row_q - 1'b1;
                  end
                  we_n   = 1'b1;
                  addr_n = cell_addr(row_n, col_n);
                  data_n = BLANK_CHAR;
               end
            end
         end
         CLEAR: begin
            if (addr_q == LAST_ADDR) begin
               busy_n = 1'b0;
               col_n  = '0;
               row_n  = '0;
            end else begin
               we_n   = 1'b1;
               addr_n = addr_q + 1'b1;
               data_n = BLANK_CHAR;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs.
   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         col_q  <= '0;
         row_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         we_q   <= we_n;
         addr_q <= addr_n;
         data_q <= data_n;
         col_q  <= col_n;
         row_q  <= row_n;
         busy_q <= busy_n;
      end
   end
endmodule

// File: tb/tb_text_cursor_controller.sv
// Self-checking bench for text_cursor_controller: vector table, directed
// corner sequences and a randomized run against a linear-position model.
module tb_text_cursor_controller;
   localparam int W     = 76;
   localparam int H     = 42;
   localparam int CELLS = W * H;

   logic clk = 1'b0;
   logic rst = 1'b0;

   text_cursor_controller_if #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) bus_if ();

   text_cursor_controller #(
      .SCREEN_WIDTH (W),
      .SCREEN_HEIGHT(H),
      .BLANK_CHAR   (8'h20)
   ) dut (
      .pixel_clk_in(clk),
      .rst_in      (rst),
      .bus         (bus_if.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: cursor held as a linear cell index.
   int         m_pos;
   logic       m_we;
   int         m_addr;
   logic [7:0] m_data;
   logic       m_busy;
   logic       m_clear;
   int         m_clr_next;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pos = 0; m_we = 1'b0; m_addr = 0; m_data = 8'h00;
      m_busy = 1'b0; m_clear = 1'b0; m_clr_next = 0;
   endtask

   task automatic model_step(input logic v, input logic [7:0] d, input logic c);
      if (m_clear) begin
         if (m_clr_next == CELLS) begin
            m_clear = 1'b0; m_we = 1'b0; m_busy = 1'b0; m_pos = 0;
         end else begin
            m_we = 1'b1; m_addr = m_clr_next; m_data = 8'h20; m_clr_next++;
         end
      end else if (c) begin
         m_clear = 1'b1; m_we = 1'b1; m_addr = 0; m_data = 8'h20;
         m_busy = 1'b1; m_clr_next = 1;
      end else begin
         m_we = 1'b0;
         if (v) begin
            if (d >= 8'h20 && d <= 8'h7E) begin
               m_we = 1'b1; m_addr = m_pos; m_data = d;
               m_pos = (m_pos + 1) % CELLS;
            end else if (d == 8'h0A) begin
               m_pos = (((m_pos / W) + 1) % H) * W;
            end else if (d == 8'h08) begin
               if (m_pos > 0) m_pos--;
               m_we = 1'b1; m_addr = m_pos; m_data = 8'h20;
            end
         end
      end
   endtask

   task automatic compare_model();
      check("te_write_en", 32'(bus_if.te_write_en), 32'(m_we));
      if (m_we) begin
         check("te_addr", 32'(bus_if.te_addr), 32'(m_addr));
         check("te_input", 32'(bus_if.te_input), 32'(m_data));
      end
      check("cursor_col", 32'(bus_if.cursor_col), 32'(m_pos % W));
      check("cursor_row", 32'(bus_if.cursor_row), 32'(m_pos / W));
      check("busy", 32'(bus_if.busy), 32'(m_busy));
   endtask

   // One clock: drive inputs, check key_ready before the edge, check outputs after it.
   task automatic tick(input logic v, input logic [7:0] d, input logic c);
      bus_if.key_valid = v;
      bus_if.key_data  = d;
      bus_if.clear_req = c;
      #1;
      check("key_ready", 32'(bus_if.key_ready), 32'(!m_clear && !c));
      @(posedge clk);
      #1;
      model_step(v, d, c);
      compare_model();
   endtask

   task automatic do_reset();
      bus_if.key_valid = 1'b0;
      bus_if.key_data  = 8'h00;
      bus_if.clear_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_we", 32'(bus_if.te_write_en), 32'd0);
      check("rst_addr", 32'(bus_if.te_addr), 32'd0);
      check("rst_input", 32'(bus_if.te_input), 32'd0);
      check("rst_col", 32'(bus_if.cursor_col), 32'd0);
      check("rst_row", 32'(bus_if.cursor_row), 32'd0);
      check("rst_busy", 32'(bus_if.busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       c;
      logic       we;
      int         addr;
      logic [7:0] data;
      int         col;
      int         row;
   } vec_t;

   vec_t vecs[11];

   initial begin
      bus_if.key_valid = 1'b0;
      bus_if.key_data  = 8'h00;
      bus_if.clear_req = 1'b0;
      model_reset();

      vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b1, 0,  8'h41, 1,  0};
      vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0,  8'h00, 1,  0};
      vecs[2]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 0,  8'h00, 0,  1};
      vecs[3]  = '{1'b1, 8'h42, 1'b0, 1'b1, 76, 8'h42, 1,  1};
      vecs[4]  = '{1'b1, 8'h08, 1'b0, 1'b1, 76, 8'h20, 0,  1};
      vecs[5]  = '{1'b1, 8'h08, 1'b0, 1'b1, 75, 8'h20, 75, 0};
      vecs[6]  = '{1'b1, 8'h07, 1'b0, 1'b0, 0,  8'h00, 75, 0};
      vecs[7]  = '{1'b1, 8'h7A, 1'b0, 1'b1, 75, 8'h7A, 0,  1};
      vecs[8]  = '{1'b1, 8'h7F, 1'b0, 1'b0, 0,  8'h00, 0,  1};
      vecs[9]  = '{1'b1, 8'h1F, 1'b0, 1'b0, 0,  8'h00, 0,  1};
      vecs[10] = '{1'b1, 8'h20, 1'b0, 1'b1, 76, 8'h20, 1,  1};

      // Vector table from reset.
      do_reset();
      for (int i = 0; i < 11; i++) begin
         tick(vecs[i].v, vecs[i].d, vecs[i].c);
         check("vec_we", 32'(bus_if.te_write_en), 32'(vecs[i].we));
         if (vecs[i].we) begin
            check("vec_addr", 32'(bus_if.te_addr), 32'(vecs[i].addr));
            check("vec_data", 32'(bus_if.te_input), 32'(vecs[i].data));
         end
         check("vec_col", 32'(bus_if.cursor_col), 32'(vecs[i].col));
         check("vec_row", 32'(bus_if.cursor_row), 32'(vecs[i].row));
      end

      // A full row of back-to-back keys, then backspace at the origin.
      do_reset();
      for (int i = 0; i < W; i++) begin
         tick(1'b1, 8'h41 + 8'(i % 26), 1'b0);
         check("row_we", 32'(bus_if.te_write_en), 32'd1);
         check("row_addr", 32'(bus_if.te_addr), 32'(i));
      end
      check("row_end_col", 32'(bus_if.cursor_col), 32'd0);
      check("row_end_row", 32'(bus_if.cursor_row), 32'd1);
      do_reset();
      tick(1'b1, 8'h08, 1'b0);
      check("bs00_addr", 32'(bus_if.te_addr), 32'd0);
      check("bs00_data", 32'(bus_if.te_input), 32'h20);
      check("bs00_col", 32'(bus_if.cursor_col), 32'd0);
      check("bs00_row", 32'(bus_if.cursor_row), 32'd0);

      // Newline on the last row wraps; bell is discarded; last-cell wrap.
      do_reset();
      for (int i = 0; i < H - 1; i++) tick(1'b1, 8'h0A, 1'b0);
      for (int i = 0; i < 10; i++) tick(1'b1, 8'h61, 1'b0);
      check("pre_nl_col", 32'(bus_if.cursor_col), 32'd10);
      check("pre_nl_row", 32'(bus_if.cursor_row), 32'd41);
      tick(1'b1, 8'h0A, 1'b0);
      check("nl_wrap_we", 32'(bus_if.te_write_en), 32'd0);
      check("nl_wrap_col", 32'(bus_if.cursor_col), 32'd0);
      check("nl_wrap_row", 32'(bus_if.cursor_row), 32'd0);
      tick(1'b1, 8'h07, 1'b0);
      check("bell_we", 32'(bus_if.te_write_en), 32'd0);
      check("bell_col", 32'(bus_if.cursor_col), 32'd0);
      for (int i = 0; i < H - 1; i++) tick(1'b1, 8'h0A, 1'b0);
      for (int i = 0; i < W - 1; i++) tick(1'b1, 8'h62, 1'b0);
      tick(1'b1, 8'h63, 1'b0);
      check("last_addr", 32'(bus_if.te_addr), 32'(CELLS - 1));
      check("last_wrap_col", 32'(bus_if.cursor_col), 32'd0);
      check("last_wrap_row", 32'(bus_if.cursor_row), 32'd0);

      // Full clear with a competing key on the request cycle.
      do_reset();
      tick(1'b1, 8'h41, 1'b0);
      tick(1'b1, 8'h44, 1'b1);
      check("clr_first_addr", 32'(bus_if.te_addr), 32'd0);
      check("clr_first_data", 32'(bus_if.te_input), 32'h20);
      for (int i = 1; i < CELLS; i++) begin
         tick(1'($urandom_range(0, 1)), 8'h5A, 1'($urandom_range(0, 1)));
         check("clr_addr", 32'(bus_if.te_addr), 32'(i));
         check("clr_busy", 32'(bus_if.busy), 32'd1);
      end
      tick(1'b0, 8'h00, 1'b0);
      check("clr_end_we", 32'(bus_if.te_write_en), 32'd0);
      check("clr_end_busy", 32'(bus_if.busy), 32'd0);
      check("clr_end_col", 32'(bus_if.cursor_col), 32'd0);
      check("clr_end_row", 32'(bus_if.cursor_row), 32'd0);

      // Reset in the middle of a clear sweep.
      tick(1'b0, 8'h00, 1'b1);
      for (int i = 1; i <= 1000; i++) tick(1'b0, 8'h00, 1'b0);
      check("mid_addr", 32'(bus_if.te_addr), 32'd1000);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("mid_rst_we", 32'(bus_if.te_write_en), 32'd0);
      check("mid_rst_busy", 32'(bus_if.busy), 32'd0);
      check("mid_rst_addr", 32'(bus_if.te_addr), 32'd0);
      check("mid_rst_ready", 32'(bus_if.key_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      tick(1'b1, 8'h51, 1'b0);
      check("post_rst_addr", 32'(bus_if.te_addr), 32'd0);
      check("post_rst_data", 32'(bus_if.te_input), 32'h51);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 12000; i++) begin
         logic [7:0] d;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 6)       d = 8'($urandom_range(8'h20, 8'h7E));
         else if (sel == 6) d = 8'h0A;
         else if (sel == 7) d = 8'h08;
         else               d = 8'($urandom_range(0, 255));
         tick(1'($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2999) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
